// File: rtl/cnn_accum_pkg.sv
`default_nettype none
// cnn_accum_pkg: shared state encoding, accumulator width and saturation limits
// for the time-multiplexed accumulation controller.
package cnn_accum_pkg;

  localparam int ACC_W = 62;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } accum_state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/accum_seq_ctrl_adder.sv
`default_nettype none
// accum_seq_ctrl_adder: plain ripple-free DATA_WIDTH adder with carry in/out,
// shared by every beat of an accumulation window.
module accum_seq_ctrl_adder #(
  parameter int DATA_WIDTH = 62
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/accum_seq_ctrl.sv
`default_nettype none
// accum_seq_ctrl: sums num_terms partial products from a valid/ready stream with one adder.
// Optional feature macro ACCUM_SAT_EN: saturating arithmetic plus sticky ovf output.
module accum_seq_ctrl
  import cnn_accum_pkg::*;
#(
  parameter int DATA_W    = ACC_W,
  parameter int MAX_TERMS = 25,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              busy
`ifdef ACCUM_SAT_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_TERMS);

  accum_state_t      state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  n_terms;
  logic [CNT_W-1:0]  n_clamped;
  logic              beat;
  logic              last_beat;
  logic              adder_co_unused;

  assign n_clamped = (num_terms > MAX_N) ? MAX_N : num_terms;
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt == (n_terms - CNT_W'(1)));
  assign out_sum   = acc;

  accum_seq_ctrl_adder #(
    .DATA_WIDTH (DATA_W)
  ) u_adder (
    .a   (acc),
    .b   (in_data),
    .cin (1'b0),
    .sum (sum),
    .co  (adder_co_unused)
  );

`ifdef ACCUM_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic sat_hit;

  // Once a window has overflowed the accumulator is frozen at its limit.
  always_comb begin
    sat_hit  = add_overflow(acc[DATA_W-1], in_data[DATA_W-1], sum[DATA_W-1]);
    acc_next = sum;
    if (ovf) begin
      acc_next = acc;
    end else if (sat_hit) begin
      acc_next = acc[DATA_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign acc_next = sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      n_terms   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ACCUM_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_terms <= n_clamped;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
`ifdef ACCUM_SAT_EN
            ovf     <= 1'b0;
`endif
            if (n_clamped == '0) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              state    <= ST_ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
`ifdef ACCUM_SAT_EN
            ovf <= ovf | sat_hit;
`endif
            if (last_beat) begin
              state     <= ST_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accum_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_accum_seq_ctrl: directed windows checked against a window-level sum model;
// handles both the wrapping and the ACCUM_SAT_EN saturating build.
module tb_accum_seq_ctrl;

  localparam int DW   = 62;
  localparam int MAXT = 25;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_terms = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_sum;
  logic          busy;
`ifdef ACCUM_SAT_EN
  logic          ovf;
`endif

  accum_seq_ctrl #(
    .DATA_W    (DW),
    .MAX_TERMS (MAXT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
`ifdef ACCUM_SAT_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  bit     mon_en = 1'b0;
  longint stim_q[$];
  longint exp_sum_q[$];
  bit     exp_ovf_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic longint wrap62(input longint s);
    longint t;
    t = s <<< 2;
    return t >>> 2;
  endfunction

  // Window-level model: sum the first min(n,MAX) terms starting at off.
  function automatic void model_window(input int nreq, input int off);
    int     n;
    longint acc;
    longint s;
    longint maxv;
    longint minv;
    bit     sat;
    n    = (nreq > MAXT) ? MAXT : nreq;
    acc  = 0;
    sat  = 1'b0;
    maxv = (longint'(1) <<< (DW - 1)) - 1;
    minv = -(longint'(1) <<< (DW - 1));
    for (int i = 0; i < n; i++) begin
      s = acc + stim_q[off + i];
`ifdef ACCUM_SAT_EN
      if (!sat) begin
        if (s > maxv) begin
          acc = maxv; sat = 1'b1;
        end else if (s < minv) begin
          acc = minv; sat = 1'b1;
        end else begin
          acc = s;
        end
      end
`else
      acc = wrap62(s);
`endif
    end
    exp_sum_q.push_back(acc);
    exp_ovf_q.push_back(sat);
  endfunction

  // Output monitor: handshake scoreboard, hold stability and DONE invariants.
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_sum;
  longint        e_sum;
  bit            e_ovf;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", $signed(out_sum), $signed(prev_sum));
      end
      if (out_valid) begin
        check("done_in_ready", in_ready, 0);
        check("done_busy", busy, 1);
        if (out_ready) begin
          if (exp_sum_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got sum %0d, expected no output", $signed(out_sum));
          end else begin
            e_sum = exp_sum_q.pop_front();
            e_ovf = exp_ovf_q.pop_front();
            check("sb_sum", $signed(out_sum), e_sum);
`ifdef ACCUM_SAT_EN
            check("sb_ovf", ovf, e_ovf);
`endif
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = out_sum;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts a window from IDLE, feeds stim_q[0..], returns at the first out_valid sample.
  task automatic run_window(input int nreq, input bit gaps);
    int n;
    int i;
    int guard;
    n     = (nreq > MAXT) ? MAXT : nreq;
    i     = 0;
    guard = 0;
    tick();
    start     = 1'b1;
    num_terms = CW'(nreq);
    tick();
    start     = 1'b0;
    num_terms = CW'($urandom);
    while (i < n && guard < 500) begin
      in_valid = gaps ? ((guard % 3) != 1) : 1'b1;
      in_data  = DW'(stim_q[i]);
      @(negedge clk);
      check("early_valid", out_valid, 0);
      if (in_valid && in_ready) i++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (i < n) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: got %0d beats, expected %0d", i, n);
    end
    model_window(nreq, 0);
    @(negedge clk);
    check("lat_out_valid", out_valid, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", busy, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs[3];
    int nhs;
    int bi;
    int guard;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_sum", $signed(out_sum), 0);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 1: reset after 3 of 10 beats, then a fresh 2-beat window
    tick();
    start = 1'b1;
    num_terms = 5'd10;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = DW'(k + 1);
      @(negedge clk);
      check("t1_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    mon_en = 1'b0;
    tick();
    @(negedge clk);
    check("t1_rst_out_valid", out_valid, 0);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    stim_q = {5, 6};
    run_window(2, 1'b0);
    check("t1_sum", $signed(out_sum), 11);
    wait_idle();

    // 2: ten consecutive beats 1..10
    stim_q = {};
    for (int k = 1; k <= 10; k++) stim_q.push_back(k);
    run_window(10, 1'b0);
    check("t2_sum", $signed(out_sum), 55);
    @(negedge clk);
    check("t2_idle_after_hs", busy, 0);
    wait_idle();

    // 3: gaps on input, downstream stalls, start ignored in DONE
    stim_q = {-7, 3, -2, 1};
    out_ready = 1'b0;
    run_window(4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("t3_valid", out_valid, 1);
      check("t3_sum", $signed(out_sum), -5);
      check("t3_in_ready", in_ready, 0);
      tick();
      start = 1'b1;
      num_terms = 5'd5;
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    start = 1'b0;
    tick();
    @(negedge clk);
    check("t3_start_ignored", busy, 0);
    check("t3_out_valid_low", out_valid, 0);
    tick();

    // 4: zero-term window and clamping of 31 to 25
    stim_q = {};
    run_window(0, 1'b0);
    check("t4_zero_sum", $signed(out_sum), 0);
    wait_idle();
    stim_q = {};
    for (int k = 1; k <= 31; k++) stim_q.push_back(k * 1000);
    run_window(31, 1'b0);
    check("t4_clamp_sum", $signed(out_sum), 325000);
    check("t4_clamp_in_ready", in_ready, 0);
    wait_idle();

    // 5: positive overflow, then overflow followed by a small term, then a clean window
    stim_q = {};
    stim_q.push_back(longint'(1) <<< 60);
    stim_q.push_back(longint'(1) <<< 60);
    run_window(2, 1'b0);
`ifdef ACCUM_SAT_EN
    check("t5_sat_sum", $signed(out_sum), (longint'(1) <<< 61) - 1);
    check("t5_ovf", ovf, 1);
`else
    check("t5_wrap_sum", $signed(out_sum), -(longint'(1) <<< 61));
`endif
    wait_idle();
    stim_q.push_back(-5);
    run_window(3, 1'b0);
    wait_idle();
    stim_q = {1, 2};
    run_window(2, 1'b0);
    check("t5_clean_sum", $signed(out_sum), 3);
    wait_idle();

    // 6: back-to-back windows of 2 with start held high
    stim_q = {10, 20, -3, 4, 7, 7};
    for (int w = 0; w < 3; w++) model_window(2, 2 * w);
    nhs = 0;
    bi = 0;
    guard = 0;
    start = 1'b1;
    num_terms = 5'd2;
    in_valid = 1'b1;
    in_data = DW'(stim_q[0]);
    while (nhs < 3 && guard < 100) begin
      @(negedge clk);
      if (in_valid && in_ready) bi++;
      if (out_valid && out_ready) begin
        hs[nhs] = cyc;
        nhs++;
      end
      tick();
      guard++;
      if (nhs == 3) start = 1'b0;
      if (bi < 6) in_data = DW'(stim_q[bi]);
      else in_valid = 1'b0;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("t6_windows", nhs, 3);
    if (nhs == 3) begin
      check("t6_period_1", hs[1] - hs[0], 4);
      check("t6_period_2", hs[2] - hs[1], 4);
    end
    wait_idle();

    check("scoreboard_drained", exp_sum_q.size(), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
